// File: rtl/candidate_match_buffer_pkg.sv
// Shared constants and types for the candidate match buffer.
// Match word layout: {proj index, stub index}.
package candidate_match_buffer_pkg;

    localparam int MEM_SIZE_DEF = 6;
    localparam int WIDTH_DEF    = 12;

    localparam int PROJ_MSB = 11;
    localparam int PROJ_LSB = 6;
    localparam int STUB_MSB = 5;
    localparam int STUB_LSB = 0;

    localparam int START_BX  = 0;
    localparam int START_RST = 1;

    typedef enum logic {
        PAGE_0 = 1'b0,
        PAGE_1 = 1'b1
    } page_t;

    // The page-select bit sits directly above the entry index.
    function automatic int page_bit(input int mem_size);
        return mem_size;
    endfunction

    localparam int PAGE_BIT = page_bit(MEM_SIZE_DEF);

    function automatic logic [WIDTH_DEF-1:0] make_match(input logic [PROJ_MSB-PROJ_LSB:0] proj,
                                                        input logic [STUB_MSB-STUB_LSB:0] stub);
        logic [WIDTH_DEF-1:0] w;
        w = '0;
        w[PROJ_MSB:PROJ_LSB] = proj;
        w[STUB_MSB:STUB_LSB] = stub;
        return w;
    endfunction

endpackage

// File: rtl/cm_dpram.sv
// Simple dual-port RAM: one write port, one registered read port, single clock.
// Only the read register is reset; the array contents are never cleared.
module cm_dpram #(
    parameter int ADDR_W = 7,
    parameter int DATA_W = 12
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            rd_data <= '0;
        end else begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/candidate_match_buffer.sv
// Two-page candidate match buffer: the engine fills one BX page while the calculator reads the other.
// Optional feature macro: CM_OVERFLOW_FLAG_EN (overflow flag; tied low when undefined).
module candidate_match_buffer
    import candidate_match_buffer_pkg::*;
#(
    parameter int MEM_SIZE = MEM_SIZE_DEF,
    parameter int WIDTH    = WIDTH_DEF
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                en_proc,
    input  logic [1:0]          start,
    output logic [1:0]          done,
    input  logic                valid_in,
    input  logic [WIDTH-1:0]    data_in,
    input  logic [MEM_SIZE-1:0] read_add,
    output logic [WIDTH-1:0]    data_out,
    output logic [MEM_SIZE-1:0] number_out,
    output logic                overflow
);

    localparam int PSEL = page_bit(MEM_SIZE);
    localparam logic [MEM_SIZE-1:0] PTR_MAX = '1;

    page_t               wr_page;
    logic [MEM_SIZE-1:0] wr_ptr;
    logic [MEM_SIZE-1:0] ptr_next;
    logic                wr_req;
    logic                full;
    logic                accept;
    logic                rst_pipe;
    logic                bx;
    logic [PSEL:0]       wr_addr;
    logic [PSEL:0]       rd_addr;

    assign rst_pipe = start[START_RST];
    assign bx       = start[START_BX];
    assign wr_req   = valid_in & en_proc;
    assign full     = (wr_ptr == PTR_MAX);
    // The last slot is never written, so the count always fits in MEM_SIZE bits.
    assign accept   = wr_req & ~full & ~rst_pipe;
    assign ptr_next = accept ? wr_ptr + MEM_SIZE'(1) : wr_ptr;
    assign wr_addr  = {wr_page, wr_ptr};
    assign rd_addr  = {~wr_page, read_add};

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_page    <= PAGE_0;
            wr_ptr     <= '0;
            number_out <= '0;
        end else if (rst_pipe) begin
            wr_page    <= PAGE_0;
            wr_ptr     <= '0;
            number_out <= '0;
        end else if (bx) begin
            number_out <= ptr_next;
            wr_page    <= page_t'(~wr_page);
            wr_ptr     <= '0;
        end else begin
            wr_ptr     <= ptr_next;
        end
    end

`ifdef CM_OVERFLOW_FLAG_EN
    logic ovf_acc;
    logic ovf_next;

    assign ovf_next = ovf_acc | (wr_req & full);

    always_ff @(posedge clk) begin
        if (!reset) begin
            ovf_acc  <= 1'b0;
            overflow <= 1'b0;
        end else if (rst_pipe) begin
            ovf_acc  <= 1'b0;
            overflow <= 1'b0;
        end else if (bx) begin
            overflow <= ovf_next;
            ovf_acc  <= 1'b0;
        end else begin
            ovf_acc  <= ovf_next;
        end
    end
`else
    assign overflow = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            done <= '0;
        end else begin
            done <= start;
        end
    end

    cm_dpram #(
        .ADDR_W(PSEL + 1),
        .DATA_W(WIDTH)
    ) u_ram (
        .clk    (clk),
        .reset  (reset),
        .we     (accept),
        .wr_addr(wr_addr),
        .wr_data(data_in),
        .rd_addr(rd_addr),
        .rd_data(data_out)
    );

endmodule

// File: tb/tb_candidate_match_buffer.sv
// Self-checking bench for candidate_match_buffer against a page/queue reference model.
// Honours CM_OVERFLOW_FLAG_EN when computing expected overflow.
module tb_candidate_match_buffer;
    import candidate_match_buffer_pkg::*;

`ifdef CM_OVERFLOW_FLAG_EN
    localparam bit OVF_EN = 1'b1;
`else
    localparam bit OVF_EN = 1'b0;
`endif
    localparam int DEPTH = 1 << PAGE_BIT;
    localparam int CAP   = DEPTH - 1;

    logic        clk = 1'b0;
    logic        reset;
    logic        en_proc;
    logic [1:0]  start;
    logic [1:0]  done;
    logic        valid_in;
    logic [11:0] data_in;
    logic [5:0]  read_add;
    logic [11:0] data_out;
    logic [5:0]  number_out;
    logic        overflow;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: a page holds the words accepted during its BX, in arrival order.
    int          m_page;
    logic [11:0] m_q[$];
    bit          m_drop;
    int          m_num;
    bit          m_ovf;
    logic [1:0]  m_done;
    logic [11:0] m_dout;
    bit          m_dval;
    logic [11:0] m_mem[2*DEPTH];
    bit          m_wr[2*DEPTH];

    always #5 clk = ~clk;

    candidate_match_buffer #(
        .MEM_SIZE(6),
        .WIDTH   (12)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .en_proc   (en_proc),
        .start     (start),
        .done      (done),
        .valid_in  (valid_in),
        .data_in   (data_in),
        .read_add  (read_add),
        .data_out  (data_out),
        .number_out(number_out),
        .overflow  (overflow)
    );

    task automatic step(input logic v, input logic [11:0] d, input logic [1:0] st,
                        input logic en, input logic [5:0] ra);
        int ridx;
        int widx;
        valid_in = v;
        data_in  = d;
        start    = st;
        en_proc  = en;
        read_add = ra;
        ridx = (1 - m_page) * DEPTH + int'(ra);
        @(posedge clk);
        m_dout = m_mem[ridx];
        m_dval = m_wr[ridx];
        m_done = st;
        if (st[1]) begin
            m_page = 0;
            m_q.delete();
            m_drop = 0;
            m_num  = 0;
            m_ovf  = 0;
        end else begin
            if (v && en) begin
                if (m_q.size() < CAP) begin
                    widx = m_page * DEPTH + m_q.size();
                    m_mem[widx] = d;
                    m_wr[widx]  = 1'b1;
                    m_q.push_back(d);
                end else begin
                    m_drop = 1;
                end
            end
            if (st[0]) begin
                m_num  = m_q.size();
                m_ovf  = OVF_EN ? m_drop : 1'b0;
                m_page = 1 - m_page;
                m_q.delete();
                m_drop = 0;
            end
        end
        #1;
    endtask

    task automatic test_reset();
        reset    = 1'b0;
        valid_in = 1'b0;
        data_in  = '0;
        start    = '0;
        en_proc  = 1'b1;
        read_add = '0;
        repeat (2) @(posedge clk);
        #1;
        m_page = 0; m_q.delete(); m_drop = 0; m_num = 0; m_ovf = 0;
        m_done = '0; m_dout = '0; m_dval = 1'b1;
        n_checks++;
        if (number_out !== 6'd0) begin n_fail++; $display("FAIL reset_number: got %0d want 0", number_out); end
        n_checks++;
        if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_overflow: got %b want 0", overflow); end
        n_checks++;
        if (data_out !== 12'h000) begin n_fail++; $display("FAIL reset_data: got %h want 000", data_out); end
        n_checks++;
        if (done !== 2'b00) begin n_fail++; $display("FAIL reset_done: got %b want 00", done); end
        reset = 1'b1;
        step(0, '0, 2'b00, 1, '0);
    endtask

    task automatic test_basic();
        logic [11:0] words[3];
        words[0] = make_match(6'd1, 6'd1);
        words[1] = make_match(6'd2, 6'd2);
        words[2] = make_match(6'd3, 6'd3);
        for (int i = 0; i < 3; i++) step(1, words[i], 2'b00, 1, '0);
        step(0, '0, 2'b01, 1, '0);
        n_checks++;
        if (number_out !== 6'd3) begin n_fail++; $display("FAIL basic_number: got %0d want 3", number_out); end
        n_checks++;
        if (done !== 2'b01) begin n_fail++; $display("FAIL basic_done: got %b want 01", done); end
        for (int i = 0; i < 3; i++) begin
            step(0, '0, 2'b00, 1, 6'(i));
            n_checks++;
            if (data_out !== words[i]) begin
                n_fail++; $display("FAIL basic_read[%0d]: got %h want %h", i, data_out, words[i]);
            end
        end
        n_checks++;
        if (words[0] !== 12'h041 || words[2] !== 12'h0C3) begin
            n_fail++; $display("FAIL basic_words: got %h %h want 041 0C3", words[0], words[2]);
        end
    endtask

    task automatic test_overflow();
        logic [11:0] w;
        logic [11:0] w62;
        w62 = '0;
        for (int i = 0; i < 70; i++) begin
            w = 12'($urandom);
            if (i == 62) w62 = w;
            step(1, w, 2'b00, 1, '0);
        end
        step(0, '0, 2'b01, 1, '0);
        n_checks++;
        if (number_out !== 6'd63) begin n_fail++; $display("FAIL ovf_number: got %0d want 63", number_out); end
        n_checks++;
        if (overflow !== OVF_EN) begin n_fail++; $display("FAIL ovf_flag: got %b want %b", overflow, OVF_EN); end
        step(0, '0, 2'b00, 1, 6'd62);
        n_checks++;
        if (data_out !== w62) begin n_fail++; $display("FAIL ovf_entry62: got %h want %h", data_out, w62); end
        step(1, 12'h111, 2'b00, 1, '0);
        step(1, 12'h222, 2'b00, 1, '0);
        step(0, '0, 2'b01, 1, '0);
        n_checks++;
        if (number_out !== 6'd2) begin n_fail++; $display("FAIL ovf_next_number: got %0d want 2", number_out); end
        n_checks++;
        if (overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_next_flag: got %b want 0", overflow); end
    endtask

    task automatic test_same_cycle();
        step(1, 12'h301, 2'b00, 1, '0);
        step(1, 12'h302, 2'b00, 1, '0);
        step(1, 12'h303, 2'b01, 1, '0);
        n_checks++;
        if (number_out !== 6'd3) begin n_fail++; $display("FAIL same_number: got %0d want 3", number_out); end
        step(1, 12'h3A0, 2'b00, 1, 6'd2);
        n_checks++;
        if (data_out !== 12'h303) begin n_fail++; $display("FAIL same_closing_entry: got %h want 303", data_out); end
        step(0, '0, 2'b01, 1, '0);
        step(0, '0, 2'b00, 1, 6'd0);
        n_checks++;
        if (data_out !== 12'h3A0) begin n_fail++; $display("FAIL same_new_first: got %h want 3A0", data_out); end
    endtask

    task automatic test_page_swap();
        step(1, 12'hAAA, 2'b00, 1, '0);
        // Read page currently holds 3A0 at index 0.
        step(0, '0, 2'b01, 1, 6'd0);
        n_checks++;
        if (data_out !== 12'h3A0) begin n_fail++; $display("FAIL swap_old_page: got %h want 3A0", data_out); end
        step(0, '0, 2'b00, 1, 6'd0);
        n_checks++;
        if (data_out !== 12'hAAA) begin n_fail++; $display("FAIL swap_new_page: got %h want AAA", data_out); end
    endtask

    task automatic test_pipe_reset();
        for (int i = 0; i < 5; i++) step(1, 12'(12'h500 + i), 2'b00, 1, '0);
        step(1, 12'h5FF, 2'b10, 1, '0);
        n_checks++;
        if (number_out !== 6'd0) begin n_fail++; $display("FAIL prst_number: got %0d want 0", number_out); end
        n_checks++;
        if (done !== 2'b10) begin n_fail++; $display("FAIL prst_done: got %b want 10", done); end
        for (int i = 0; i < 3; i++) step(1, 12'(12'h600 + i), 2'b00, 1, '0);
        step(0, '0, 2'b01, 1, '0);
        n_checks++;
        if (number_out !== 6'd3) begin n_fail++; $display("FAIL prst_next_number: got %0d want 3", number_out); end
        step(0, '0, 2'b00, 1, 6'd0);
        n_checks++;
        if (data_out !== 12'h600) begin n_fail++; $display("FAIL prst_next_first: got %h want 600", data_out); end
    endtask

    task automatic test_en_proc();
        for (int i = 0; i < 4; i++) step(1, 12'(12'h700 + i), 2'b00, 0, '0);
        step(0, '0, 2'b01, 1, '0);
        n_checks++;
        if (number_out !== 6'd0) begin n_fail++; $display("FAIL enproc_number: got %0d want 0", number_out); end
        step(0, '0, 2'b01, 1, '0);
        n_checks++;
        if (number_out !== 6'd0) begin n_fail++; $display("FAIL b2b_number: got %0d want 0", number_out); end
    endtask

    task automatic test_random();
        logic [1:0] st;
        for (int i = 0; i < 600; i++) begin
            st[0] = ($urandom_range(0, 24) == 0);
            st[1] = ($urandom_range(0, 149) == 0);
            step(logic'($urandom_range(0, 3) != 0), 12'($urandom), st,
                 logic'($urandom_range(0, 7) != 0), 6'($urandom_range(0, 63)));
            n_checks++;
            if (number_out !== 6'(m_num)) begin
                n_fail++; $display("FAIL rand_number cyc %0d: got %0d want %0d", i, number_out, m_num);
            end
            n_checks++;
            if (overflow !== m_ovf) begin
                n_fail++; $display("FAIL rand_overflow cyc %0d: got %b want %b", i, overflow, m_ovf);
            end
            n_checks++;
            if (done !== m_done) begin
                n_fail++; $display("FAIL rand_done cyc %0d: got %b want %b", i, done, m_done);
            end
            if (m_dval) begin
                n_checks++;
                if (data_out !== m_dout) begin
                    n_fail++; $display("FAIL rand_data cyc %0d: got %h want %h", i, data_out, m_dout);
                end
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 2 * DEPTH; i++) begin
            m_mem[i] = '0;
            m_wr[i]  = 1'b0;
        end
        test_reset();
        test_basic();
        test_overflow();
        test_same_cycle();
        test_page_swap();
        test_pipe_reset();
        test_en_proc();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/candidate_match_buffer.md
# candidate_match_buffer

Buffers the candidate matches emitted by the match engine, one page per bunch crossing (BX), and serves the last completed page to the downstream match calculator. It has two BX pages: the engine writes one while the calculator reads the other. At each BX boundary the pages swap and the number of matches in the closed page is published.

## Interface
Parameters:
- MEM_SIZE, 6, log2 of page depth. Usable entries per page are 2^MEM_SIZE − 1 = 63, so the count fits in MEM_SIZE bits.
- WIDTH, 12, match word width: {proj index[11:6], stub index[5:0]}.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-low reset.
- en_proc  in  1  processing enable; when low, writes are ignored. Reads and page swap are unaffected.
- start  in  2  [0] = BX boundary strobe; [1] = pipelined reset.
- done  out  2  start delayed by exactly 1 cycle.
- valid_in  in  1  match valid, from the match engine's valid_data.
- data_in  in  WIDTH  match word, from the match engine's matchout.
- read_add  in  MEM_SIZE  entry index in the readable page.
- data_out  out  WIDTH  registered read data.
- number_out  out  MEM_SIZE  entry count of the readable page.
- overflow  out  1  readable page dropped at least one match.

## Operation
- State:
  - wr_page (1 b): page being written; the read page is always ~wr_page.
  - wr_ptr (MEM_SIZE b): next write index in the write page.
  - ovf_acc (1 b): overflow accumulator for the write page.
- Write: when valid_in & en_proc and wr_ptr < 2^MEM_SIZE−1:
  - mem[{wr_page, wr_ptr}] <= data_in;
  - wr_ptr++.
- Full: when valid_in & en_proc and wr_ptr == 2^MEM_SIZE−1:
  - the word is dropped;
  - wr_ptr holds (saturates, no wrap);
  - ovf_acc <= 1.
- BX boundary (start[0]=1):
  - A write or drop in the same cycle is applied to the closing page first.
  - Then: number_out <= post-write wr_ptr; overflow <= post-drop ovf_acc; wr_page toggles; wr_ptr <= 0; ovf_acc <= 0.
- Pipelined reset (start[1]=1), takes priority over start[0]:
  - wr_page <= 0, wr_ptr <= 0, ovf_acc <= 0;
  - number_out <= 0, overflow <= 0;
  - the in-flight write in that cycle is discarded;
  - memory contents are not cleared.
- reset=0 (synchronous):
  - wr_page = 0, wr_ptr = 0, ovf_acc = 0;
  - number_out = 0, overflow = 0, data_out = 0, done = 0.
- Reads: data_out <= mem[{~wr_page, read_add}], using the wr_page value before this edge. Reading index ≥ number_out returns stale contents; no error is raised.

## Timing
- Write-to-readable latency: a match written in BX n is readable from the cycle after the start[0] that closes BX n.
- Read latency: 1 cycle, read_add at edge k → data_out valid after edge k+1.
- Page-swap edge: a read issued in the same cycle as start[0] returns the old read page. The next read returns the new read page.
- number_out and overflow update 1 cycle after start[0] and hold until the next start[0], start[1], or reset.
- done = start registered once.
- Back-to-back start[0] with no writes: number_out = 0 and pages still toggle.

## Configuration
- CM_OVERFLOW_FLAG_EN:
  - Defined: ovf_acc and overflow behave as described above.
  - Undefined: the overflow logic is not compiled; overflow is tied to 0. Saturation and drop behaviour are unchanged.

## Structure
- Shared package holds:
  - MEM_SIZE default;
  - match word width and field offsets (proj index 11:6, stub index 5:0);
  - page-select bit position.
- One sub-module, cm_dpram: simple dual-port RAM, 2^(MEM_SIZE+1) × WIDTH, one write port and one registered read port, same clk.

## Test plan
- Reset, then 3 writes (0x041, 0x082, 0x0C3), then start[0]:
  - number_out = 3 one cycle later;
  - read_add 0..2 → data_out 0x041, 0x082, 0x0C3, each 1 cycle after its read_add.
- 70 writes in one BX, then start[0]:
  - number_out = 63, overflow = 1;
  - entry 62 holds the 63rd word;
  - next BX with 2 writes → number_out = 2, overflow = 0.
- valid_in in the same cycle as start[0]:
  - the word appears in the closing page at index wr_ptr;
  - number_out includes it;
  - the new page's first write lands at index 0.
- Read at read_add=0 issued in the start[0] cycle → old page data. The read in the following cycle → new page data.
- start[1] mid-BX after 5 writes:
  - number_out = 0, done[1] = 1 one cycle later;
  - the next BX counts from 0.
- en_proc=0 with 4 valid_in pulses, then start[0] → number_out = 0.
